// File: rtl/prog_loader_if.sv
// Boot-loader link bundle: inbound program byte stream plus the loader side of the RAM bus mux.
// master = the loader, slave = whoever feeds bytes and watches the RAM port.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              bus_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wr;

  modport master (
    input  in_valid, in_data, in_last,
    output in_ready, bus_sel, mem_addr, mem_wdata, mem_wr
  );

  modport slave (
    output in_valid, in_data, in_last,
    input  in_ready, bus_sel, mem_addr, mem_wdata, mem_wr
  );
endinterface

// File: rtl/prog_loader.sv
// Boot stage for the 8-bit cpu: streams a program into RAM while the cpu is held in reset,
// releases it, then counts run cycles until halt or timeout.
module prog_loader #(
  parameter int unsigned       ADDR_W    = 13,
  parameter int unsigned       DATA_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       MAX_BYTES = 8192,
  parameter int unsigned       WR_CYCLES = 2,
  parameter int unsigned       CNT_W     = 16,
  parameter int unsigned       TIMEOUT   = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cpu_halt,
  prog_loader_if.master     bus,
  output logic              cpu_reset,
  output logic [ADDR_W:0]   byte_count,
  output logic [CNT_W-1:0]  run_cycles,
  output logic              done,
  output logic [1:0]        err
);

  localparam int unsigned       WC_W    = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam logic [WC_W-1:0]   WC_LAST = WC_W'(WR_CYCLES - 1);
  localparam logic [ADDR_W:0]   MAX_CNT = (ADDR_W+1)'(MAX_BYTES);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  RUN_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]  TO_M1   = CNT_W'(TIMEOUT - 1);
  localparam bit                TO_EN   = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_RELEASE, S_RUN, S_HALTED, S_ERROR
  } state_e;

  state_e            state_q,      state_d;
  logic              cpu_reset_q,  cpu_reset_d;
  logic              bus_sel_q,    bus_sel_d;
  logic              mem_wr_q,     mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
  logic [ADDR_W:0]   byte_count_q, byte_count_d;
  logic [CNT_W-1:0]  run_cycles_q, run_cycles_d;
  logic              done_q,       done_d;
  logic [1:0]        err_q,        err_d;
  logic              last_q,       last_d;
  logic              ovf_q,        ovf_d;
  logic [WC_W-1:0]   wr_cnt_q,     wr_cnt_d;
  logic [ADDR_W:0]   cnt_inc;

  assign cnt_inc = byte_count_q + CNT_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cpu_reset_q  <= 1'b1;
      bus_sel_q    <= 1'b1;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= BASE_ADDR;
      mem_wdata_q  <= '0;
      byte_count_q <= '0;
      run_cycles_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 2'b00;
      last_q       <= 1'b0;
      ovf_q        <= 1'b0;
      wr_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      cpu_reset_q  <= cpu_reset_d;
      bus_sel_q    <= bus_sel_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      byte_count_q <= byte_count_d;
      run_cycles_q <= run_cycles_d;
      done_q       <= done_d;
      err_q        <= err_d;
      last_q       <= last_d;
      ovf_q        <= ovf_d;
      wr_cnt_q     <= wr_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cpu_reset_d  = cpu_reset_q;
    bus_sel_d    = bus_sel_q;
    mem_wr_d     = mem_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    byte_count_d = byte_count_q;
    run_cycles_d = run_cycles_q;
    done_d       = done_q;
    err_d        = err_q;
    last_d       = last_q;
    ovf_d        = ovf_q;
    wr_cnt_d     = wr_cnt_q;
    unique case (state_q)
      S_IDLE, S_HALTED, S_ERROR: begin
        if (start) begin
          state_d      = S_LOAD;
          cpu_reset_d  = 1'b1;
          bus_sel_d    = 1'b1;
          mem_addr_d   = BASE_ADDR;
          byte_count_d = '0;
          err_d        = 2'b00;
          ovf_d        = 1'b0;
          done_d       = 1'b0;
        end
      end
      S_LOAD: begin
        if (bus.in_valid) begin
          // Once MAX_BYTES are in, the next accepted byte is dropped, even if it carries last.
          if (ovf_q) begin
            state_d = S_ERROR;
            err_d   = 2'b01;
          end else begin
            state_d     = S_WRITE;
            mem_wdata_d = bus.in_data;
            last_d      = bus.in_last;
            mem_wr_d    = 1'b1;
            wr_cnt_d    = '0;
          end
        end
      end
      S_WRITE: begin
        if (wr_cnt_q == WC_LAST) begin
          mem_wr_d     = 1'b0;
          byte_count_d = cnt_inc;
          mem_addr_d   = mem_addr_q + ADR_ONE;
          if (last_q) begin
            state_d = S_RELEASE;
          end else begin
            state_d = S_LOAD;
            if (cnt_inc == MAX_CNT) ovf_d = 1'b1;
          end
        end else begin
          wr_cnt_d = wr_cnt_q + WC_W'(1);
        end
      end
      S_RELEASE: begin
        state_d      = S_RUN;
        bus_sel_d    = 1'b0;
        cpu_reset_d  = 1'b0;
        run_cycles_d = '0;
      end
      S_RUN: begin
        // Halt takes priority over a timeout landing on the same cycle.
        if (cpu_halt) begin
          state_d = S_HALTED;
          done_d  = 1'b1;
        end else begin
          if (run_cycles_q != '1) run_cycles_d = run_cycles_q + RUN_ONE;
          if (TO_EN && (run_cycles_q == TO_M1)) begin
            state_d     = S_ERROR;
            err_d       = 2'b10;
            cpu_reset_d = 1'b1;
            bus_sel_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == S_LOAD);
  assign bus.bus_sel   = bus_sel_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wr    = mem_wr_q;
  assign cpu_reset     = cpu_reset_q;
  assign byte_count    = byte_count_q;
  assign run_cycles    = run_cycles_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench: dut_a (MAX_BYTES=4, no timeout) covers load/run/halt/overflow/reset-abort,
// dut_b (TIMEOUT=50) covers the run timeout.
module tb_prog_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic halt_a = 1'b0, halt_b = 1'b0;
  logic        cpu_reset_a, cpu_reset_b;
  logic [13:0] byte_count_a, byte_count_b;
  logic [15:0] run_cycles_a, run_cycles_b;
  logic        done_a, done_b;
  logic [1:0]  err_a, err_b;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_W(13), .DATA_W(8)) ifa ();
  prog_loader_if #(.ADDR_W(13), .DATA_W(8)) ifb ();

  prog_loader #(.MAX_BYTES(4), .TIMEOUT(0)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .cpu_halt(halt_a), .bus(ifa),
    .cpu_reset(cpu_reset_a), .byte_count(byte_count_a), .run_cycles(run_cycles_a),
    .done(done_a), .err(err_a)
  );

  prog_loader #(.TIMEOUT(50)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .cpu_halt(halt_b), .bus(ifb),
    .cpu_reset(cpu_reset_b), .byte_count(byte_count_b), .run_cycles(run_cycles_b),
    .done(done_b), .err(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with dut_a in LOAD; returns at the negedge after the write completes.
  task automatic wr_byte_a(input logic [7:0] d, input logic last, input logic [12:0] addr,
                           input logic [13:0] cnt_after);
    chk("a_ready_load", ifa.in_ready, 1);
    ifa.in_valid = 1'b1;
    ifa.in_data  = d;
    ifa.in_last  = last;
    @(negedge clk);
    chk("a_wr_c1", ifa.mem_wr, 1);
    chk("a_addr_c1", ifa.mem_addr, addr);
    chk("a_wdata", ifa.mem_wdata, d);
    chk("a_ready_wr", ifa.in_ready, 0);
    @(negedge clk);
    chk("a_wr_c2", ifa.mem_wr, 1);
    chk("a_addr_c2", ifa.mem_addr, addr);
    chk("a_wdata_c2", ifa.mem_wdata, d);
    @(negedge clk);
    chk("a_wr_end", ifa.mem_wr, 0);
    chk("a_addr_inc", ifa.mem_addr, addr + 13'd1);
    chk("a_count", byte_count_a, cnt_after);
  endtask

  initial begin
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_last = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.in_last = 1'b0;
    repeat (2) @(negedge clk);
    // reset state
    chk("rst_cpu_reset", cpu_reset_a, 1);
    chk("rst_bus_sel", ifa.bus_sel, 1);
    chk("rst_in_ready", ifa.in_ready, 0);
    chk("rst_mem_wr", ifa.mem_wr, 0);
    chk("rst_mem_addr", ifa.mem_addr, 0);
    chk("rst_mem_wdata", ifa.mem_wdata, 0);
    chk("rst_byte_count", byte_count_a, 0);
    chk("rst_run_cycles", run_cycles_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_b_cpu_reset", cpu_reset_b, 1);
    chk("rst_b_ready", ifb.in_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", ifa.in_ready, 0);

    // 1: load A0,B1,C2 with valid held high
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wr_byte_a(8'hA0, 1'b0, 13'd0, 14'd1);
    wr_byte_a(8'hB1, 1'b0, 13'd1, 14'd2);
    wr_byte_a(8'hC2, 1'b1, 13'd2, 14'd3);
    ifa.in_valid = 1'b0; ifa.in_last = 1'b0;
    chk("rel_ready", ifa.in_ready, 0);
    chk("rel_cpu_reset", cpu_reset_a, 1);
    @(negedge clk);
    chk("run_cpu_reset", cpu_reset_a, 0);
    chk("run_bus_sel", ifa.bus_sel, 0);
    chk("run_cycles0", run_cycles_a, 0);

    // 2: halt after 100 run cycles; start in RUN ignored
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("run_start_ign", cpu_reset_a, 0);
    repeat (99) @(negedge clk);
    chk("run_cycles100", run_cycles_a, 100);
    halt_a = 1'b1;
    @(negedge clk);
    halt_a = 1'b0;
    chk("halt_done", done_a, 1);
    chk("halt_cycles", run_cycles_a, 100);
    chk("halt_err", err_a, 0);
    chk("halt_cpu_reset", cpu_reset_a, 0);
    @(negedge clk);
    chk("halt_cycles_hold", run_cycles_a, 100);
    chk("halt_done_hold", done_a, 1);

    // 3+5: restart, gaps in valid with start/halt pulses in LOAD, then overflow
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("rs_cpu_reset", cpu_reset_a, 1);
    chk("rs_bus_sel", ifa.bus_sel, 1);
    chk("rs_done", done_a, 0);
    chk("rs_count", byte_count_a, 0);
    chk("rs_addr", ifa.mem_addr, 0);
    wr_byte_a(8'h10, 1'b0, 13'd0, 14'd1);
    ifa.in_valid = 1'b0;
    start_a = 1'b1; halt_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start_a = 1'b0; halt_a = 1'b0;
      chk("gap_ready", ifa.in_ready, 1);
      chk("gap_mem_wr", ifa.mem_wr, 0);
      chk("gap_count", byte_count_a, 1);
      chk("gap_done", done_a, 0);
    end
    wr_byte_a(8'h21, 1'b0, 13'd1, 14'd2);
    wr_byte_a(8'h32, 1'b0, 13'd2, 14'd3);
    wr_byte_a(8'h43, 1'b0, 13'd3, 14'd4);
    ifa.in_data = 8'h54; ifa.in_last = 1'b1;
    @(negedge clk);
    ifa.in_valid = 1'b0; ifa.in_last = 1'b0;
    chk("ovf_err", err_a, 1);
    chk("ovf_mem_wr", ifa.mem_wr, 0);
    chk("ovf_count", byte_count_a, 4);
    chk("ovf_cpu_reset", cpu_reset_a, 1);
    chk("ovf_ready", ifa.in_ready, 0);
    @(negedge clk);
    chk("ovf_err_sticky", err_a, 1);
    chk("ovf_no_wr", ifa.mem_wr, 0);

    // 6: reset during 2nd write cycle, then reload from BASE_ADDR
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("clr_err", err_a, 0);
    chk("clr_count", byte_count_a, 0);
    wr_byte_a(8'h11, 1'b0, 13'd0, 14'd1);
    ifa.in_data = 8'h22;
    @(negedge clk);
    chk("ab_wr_c1", ifa.mem_wr, 1);
    chk("ab_addr_c1", ifa.mem_addr, 1);
    @(negedge clk);
    chk("ab_wr_c2", ifa.mem_wr, 1);
    reset = 1'b1; ifa.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("ab_mem_wr", ifa.mem_wr, 0);
    chk("ab_addr", ifa.mem_addr, 0);
    chk("ab_cpu_reset", cpu_reset_a, 1);
    chk("ab_count", byte_count_a, 0);
    chk("ab_wdata", ifa.mem_wdata, 0);
    @(negedge clk);
    chk("ab_idle_ready", ifa.in_ready, 0);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wr_byte_a(8'h33, 1'b1, 13'd0, 14'd1);
    ifa.in_valid = 1'b0; ifa.in_last = 1'b0;
    @(negedge clk);
    chk("rl_cpu_reset", cpu_reset_a, 0);
    chk("rl_bus_sel", ifa.bus_sel, 0);

    // 4: dut_b timeout after 50 run cycles
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("b_ready", ifb.in_ready, 1);
    ifb.in_valid = 1'b1; ifb.in_data = 8'h5A; ifb.in_last = 1'b1;
    @(negedge clk);
    ifb.in_valid = 1'b0; ifb.in_last = 1'b0;
    chk("b_wr", ifb.mem_wr, 1);
    repeat (2) @(negedge clk);
    chk("b_count", byte_count_b, 1);
    @(negedge clk);
    chk("b_run_cycles0", run_cycles_b, 0);
    chk("b_run_cpu_reset", cpu_reset_b, 0);
    repeat (49) @(negedge clk);
    chk("b_pre_to_cpu_reset", cpu_reset_b, 0);
    chk("b_pre_to_err", err_b, 0);
    @(negedge clk);
    chk("b_to_err", err_b, 2);
    chk("b_to_cpu_reset", cpu_reset_b, 1);
    chk("b_to_bus_sel", ifb.bus_sel, 1);
    chk("b_to_done", done_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end
endmodule
